// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-Stream FIFO: address sizing, beat layout and
// operating-mode encodings.
package axis_fifo_pkg;

    localparam int AXIS_DW     = 24;
    localparam int MODE_STREAM = 0;
    localparam int MODE_PACKET = 1;

    // Beat layout as stored in the buffer; tlast sits above tdata.
    typedef struct packed {
        logic               tlast;
        logic [AXIS_DW-1:0] tdata;
    } axis_beat_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (fall-through) read.
// Contents are never cleared; reset only affects the pointers in the parent.
module axis_fifo_ram #(
    parameter  int WIDTH = 25,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with cut-through (stream) or store-and-forward (packet) release,
// occupancy count and almost-full/almost-empty flags.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int DEPTH       = 256,
    parameter int PACKET_MODE = MODE_STREAM,
    parameter int AFULL_TH    = DEPTH - 4,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    forced_commit
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LP_DEPTH  = PW'(DEPTH);
    localparam logic [PW-1:0] LP_AFULL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] LP_AEMPTY = PW'(AEMPTY_TH);
    localparam logic [PW-1:0] LP_ONE    = PW'(1);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         w_commit_ptr;
    logic [PW-1:0]         w_avail;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH:0]   w_rd_beat;

    // Valid/ready: a beat moves on a side only in a cycle where both valid and
    // ready are high at the rising edge; valid never waits on ready.
    assign count         = r_wr_ptr - r_rd_ptr;
    assign w_full        = (count == LP_DEPTH);
    assign w_avail       = w_commit_ptr - r_rd_ptr;
    assign s_axis_tready = !w_full;
    assign m_axis_tvalid = (w_avail != '0);
    assign w_wr_en       = s_axis_tvalid && s_axis_tready;
    assign w_rd_en       = m_axis_tvalid && m_axis_tready;
    assign almost_full   = (count >= LP_AFULL);
    assign almost_empty  = (count <= LP_AEMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + LP_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + LP_ONE;
            end
        end
    end

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({s_axis_tlast, s_axis_tdata}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_beat)
    );

    assign {m_axis_tlast, m_axis_tdata} = w_rd_beat;

    generate
        if (PACKET_MODE == MODE_PACKET) begin : g_packet
            logic [PW-1:0] r_commit_ptr;
            logic          r_cut_through;
            logic          r_forced;
            logic          w_oversize;

            // Full with nothing releasable means one packet larger than the
            // buffer: release what is held and pass the rest until its tlast.
            assign w_oversize = w_full && (w_avail == '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_commit_ptr  <= '0;
                    r_cut_through <= 1'b0;
                    r_forced      <= 1'b0;
                end else begin
                    r_forced <= w_oversize;
                    if (w_oversize) begin
                        r_commit_ptr  <= r_wr_ptr;
                        r_cut_through <= 1'b1;
                    end else if (w_wr_en && (s_axis_tlast || r_cut_through)) begin
                        r_commit_ptr <= r_wr_ptr + LP_ONE;
                        if (s_axis_tlast) begin
                            r_cut_through <= 1'b0;
                        end
                    end
                end
            end

            assign w_commit_ptr  = r_commit_ptr;
            assign forced_commit = r_forced;
        end else begin : g_stream
            assign w_commit_ptr  = r_wr_ptr;
            assign forced_commit = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one stream-mode and one packet-mode instance
// (DEPTH=8, AFULL_TH=6, AEMPTY_TH=2) checked against a beat scoreboard.
module tb_axis_pkt_fifo;

    logic clk;
    logic reset;

    logic [23:0] st_s_tdata, pk_s_tdata;
    logic        st_s_tvalid, pk_s_tvalid;
    logic        st_s_tready, pk_s_tready;
    logic        st_s_tlast, pk_s_tlast;
    logic [23:0] st_m_tdata, pk_m_tdata;
    logic        st_m_tvalid, pk_m_tvalid;
    logic        st_m_tready, pk_m_tready;
    logic        st_m_tlast, pk_m_tlast;
    logic [3:0]  st_count, pk_count;
    logic        st_af, pk_af, st_ae, pk_ae, st_fc, pk_fc;

    int n_tests = 0;
    int n_fail  = 0;
    int pk_fc_pulses = 0;

    logic [24:0] st_q[$];
    logic [24:0] pk_q[$];

    axis_pkt_fifo #(
        .DATA_WIDTH (24), .DEPTH (8), .PACKET_MODE (0), .AFULL_TH (6), .AEMPTY_TH (2)
    ) u_st (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (st_s_tdata),
        .s_axis_tvalid (st_s_tvalid),
        .s_axis_tready (st_s_tready),
        .s_axis_tlast  (st_s_tlast),
        .m_axis_tdata  (st_m_tdata),
        .m_axis_tvalid (st_m_tvalid),
        .m_axis_tready (st_m_tready),
        .m_axis_tlast  (st_m_tlast),
        .count         (st_count),
        .almost_full   (st_af),
        .almost_empty  (st_ae),
        .forced_commit (st_fc)
    );

    axis_pkt_fifo #(
        .DATA_WIDTH (24), .DEPTH (8), .PACKET_MODE (1), .AFULL_TH (6), .AEMPTY_TH (2)
    ) u_pk (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (pk_s_tdata),
        .s_axis_tvalid (pk_s_tvalid),
        .s_axis_tready (pk_s_tready),
        .s_axis_tlast  (pk_s_tlast),
        .m_axis_tdata  (pk_m_tdata),
        .m_axis_tvalid (pk_m_tvalid),
        .m_axis_tready (pk_m_tready),
        .m_axis_tlast  (pk_m_tlast),
        .count         (pk_count),
        .almost_full   (pk_af),
        .almost_empty  (pk_ae),
        .forced_commit (pk_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one beat and returns #1 after the edge that accepted it, leaving
    // tvalid high so consecutive calls stream back-to-back.
    task automatic send(input bit pk, input logic [23:0] d, input logic l);
        if (pk) begin
            pk_s_tdata = d; pk_s_tlast = l; pk_s_tvalid = 1'b1;
        end else begin
            st_s_tdata = d; st_s_tlast = l; st_s_tvalid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((pk && pk_s_tready) || (!pk && st_s_tready)) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: pops before pushes so a same-cycle bypass would be caught.
    always @(negedge clk) begin
        if (reset) begin
            st_q.delete();
            pk_q.delete();
        end else begin
            if (pk_fc) pk_fc_pulses++;
            if (st_m_tvalid && st_m_tready) begin
                if (st_q.size() == 0) check("st_underflow", 32'({st_m_tlast, st_m_tdata}), 32'hFFFF_FFFF);
                else check("st_beat", 32'({st_m_tlast, st_m_tdata}), 32'(st_q.pop_front()));
            end
            if (pk_m_tvalid && pk_m_tready) begin
                if (pk_q.size() == 0) check("pk_underflow", 32'({pk_m_tlast, pk_m_tdata}), 32'hFFFF_FFFF);
                else check("pk_beat", 32'({pk_m_tlast, pk_m_tdata}), 32'(pk_q.pop_front()));
            end
            if (st_s_tvalid && st_s_tready) st_q.push_back({st_s_tlast, st_s_tdata});
            if (pk_s_tvalid && pk_s_tready) pk_q.push_back({pk_s_tlast, pk_s_tdata});
        end
    end

    initial begin
        reset = 1'b1;
        st_s_tdata = '0; st_s_tvalid = 1'b0; st_s_tlast = 1'b0; st_m_tready = 1'b0;
        pk_s_tdata = '0; pk_s_tvalid = 1'b0; pk_s_tlast = 1'b0; pk_m_tready = 1'b0;
        cycles(3);

        // Reset values on both instances
        check("rst_st_tready", 32'(st_s_tready), 32'd1);
        check("rst_st_tvalid", 32'(st_m_tvalid), 32'd0);
        check("rst_st_count",  32'(st_count),    32'd0);
        check("rst_st_ae",     32'(st_ae),       32'd1);
        check("rst_st_af",     32'(st_af),       32'd0);
        check("rst_pk_tvalid", 32'(pk_m_tvalid), 32'd0);
        check("rst_pk_fc",     32'(pk_fc),       32'd0);
        reset = 1'b0;
        cycles(1);

        // Stream fill 1..8 with consumer stalled; flags tracked per beat
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, 24'(i), 1'b0);
            check("fill_count", 32'(st_count), 32'(i));
            check("fill_ae",    32'(st_ae),    32'(i <= 2));
            check("fill_af",    32'(st_af),    32'(i >= 6));
            if (i == 1) check("fill_latency", 32'(st_m_tvalid), 32'd1);
        end
        st_s_tvalid = 1'b0;
        check("full_tready", 32'(st_s_tready), 32'd0);
        check("full_count",  32'(st_count),    32'd8);
        st_m_tready = 1'b1;
        cycles(8);
        check("drain_count",  32'(st_count),    32'd0);
        check("drain_tvalid", 32'(st_m_tvalid), 32'd0);

        // Simultaneous read and write at count 4
        st_m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 24'($urandom_range(0, 24'hFFFFFF)), 1'($urandom_range(0, 1)));
        check("rw_pre_count", 32'(st_count), 32'd4);
        st_m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 24'($urandom_range(0, 24'hFFFFFF)), 1'($urandom_range(0, 1)));
            check("rw_count", 32'(st_count), 32'd4);
        end
        st_s_tvalid = 1'b0;
        cycles(4);
        check("rw_drain_count", 32'(st_count), 32'd0);

        // Packet mode: three beats held until the tlast write
        pk_m_tready = 1'b1;
        send(1'b1, 24'hAAAAA1, 1'b0);
        check("pkt_hold1", 32'(pk_m_tvalid), 32'd0);
        send(1'b1, 24'hAAAAA2, 1'b0);
        check("pkt_hold2", 32'(pk_m_tvalid), 32'd0);
        check("pkt_count", 32'(pk_count),    32'd2);
        send(1'b1, 24'hAAAAA3, 1'b1);
        pk_s_tvalid = 1'b0;
        check("pkt_release", 32'(pk_m_tvalid), 32'd1);
        check("pkt_first_tlast", 32'(pk_m_tlast), 32'd0);
        cycles(3);
        check("pkt_drain_count", 32'(pk_count), 32'd0);

        // Packet mode: 10-beat packet into an 8-deep buffer
        pk_m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(1'b1, 24'(32'h100 + i), 1'b0);
        pk_s_tvalid = 1'b0;
        check("ovs_count",   32'(pk_count),    32'd8);
        check("ovs_tready",  32'(pk_s_tready), 32'd0);
        check("ovs_tvalid0", 32'(pk_m_tvalid), 32'd0);
        check("ovs_fc0",     32'(pk_fc),       32'd0);
        cycles(1);
        check("ovs_fc1",     32'(pk_fc),       32'd1);
        check("ovs_tvalid1", 32'(pk_m_tvalid), 32'd1);
        cycles(1);
        check("ovs_fc2",     32'(pk_fc),       32'd0);
        pk_m_tready = 1'b1;
        cycles(8);
        check("ovs_drain_count", 32'(pk_count), 32'd0);
        send(1'b1, 24'h109, 1'b0);
        check("ovs_cut_through", 32'(pk_m_tvalid), 32'd1);
        send(1'b1, 24'h10A, 1'b1);
        pk_s_tvalid = 1'b0;
        cycles(2);
        check("ovs_tail_count", 32'(pk_count), 32'd0);
        check("ovs_pulses",     32'(pk_fc_pulses), 32'd1);
        send(1'b1, 24'h000011, 1'b0);
        check("post_ovs_hold", 32'(pk_m_tvalid), 32'd0);
        send(1'b1, 24'h000012, 1'b1);
        pk_s_tvalid = 1'b0;
        check("post_ovs_release", 32'(pk_m_tvalid), 32'd1);
        cycles(3);
        check("post_ovs_count", 32'(pk_count), 32'd0);

        // Asynchronous reset in the middle of a 5-beat partial packet
        pk_m_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b1, 24'(32'hC00 + i), 1'b0);
        pk_s_tvalid = 1'b0;
        check("mid_count", 32'(pk_count), 32'd5);
        #2 reset = 1'b1;
        #1;
        check("async_count",  32'(pk_count),    32'd0);
        check("async_tready", 32'(pk_s_tready), 32'd1);
        check("async_tvalid", 32'(pk_m_tvalid), 32'd0);
        check("async_ae",     32'(pk_ae),       32'd1);
        check("async_af",     32'(pk_af),       32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pk_m_tready = 1'b1;
        send(1'b1, 24'h0000B1, 1'b0);
        check("fresh_hold", 32'(pk_m_tvalid), 32'd0);
        send(1'b1, 24'h0000B2, 1'b1);
        pk_s_tvalid = 1'b0;
        cycles(3);
        check("fresh_count",  32'(pk_count),    32'd0);
        check("fresh_tvalid", 32'(pk_m_tvalid), 32'd0);

        check("st_q_empty", 32'(st_q.size()), 32'd0);
        check("pk_q_empty", 32'(pk_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
